b2b_link_agent: RTL

- Parametrised multi-channel agent for back-to-back testbench links. Two instances are cross-connected: A.lnk_tx_* to B.lnk_rx_*, and B.lnk_tx_* to A.lnk_rx_*.
- Each channel has its own host TX FIFO. A round-robin arbiter multiplexes these FIFOs onto one tagged valid/ready link.
- The RX side demultiplexes tagged words into per-channel single-entry output registers.
- Internal loopback and traffic counters let a bench self-check with a single instance.

---
 rtl/b2b_link_pkg.sv | 11 +
 rtl/b2b_sync_fifo.sv | 44 ++++
 rtl/b2b_link_agent.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/b2b_link_pkg.sv
// rtl/b2b_link_pkg.sv - shared helpers for the back-to-back link agent
package b2b_link_pkg;

    localparam int CNT_RESET = 0;

    // Channel tag width; a single-channel agent still carries a 1-bit tag.
    function automatic int ch_width(input int n_ch);
        return (n_ch <= 1) ? 1 : $clog2(n_ch);
    endfunction

endpackage

// File: rtl/b2b_sync_fifo.sv
// rtl/b2b_sync_fifo.sv - synchronous FIFO with extra-bit pointer wrap
module b2b_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    // A full FIFO may still take a word when the head leaves on the same edge.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/b2b_link_agent.sv
// rtl/b2b_link_agent.sv - multi-channel tagged link agent with RR arbiter and loopback
module b2b_link_agent
    import b2b_link_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16,
    localparam int CH_W      = ch_width(N_CH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   loopback,
    input  logic [N_CH-1:0]        tx_valid,
    output logic [N_CH-1:0]        tx_ready,
    input  logic [N_CH*DATA_W-1:0] tx_data,
    output logic                   lnk_tx_valid,
    input  logic                   lnk_tx_ready,
    output logic [DATA_W-1:0]      lnk_tx_data,
    output logic [CH_W-1:0]        lnk_tx_chan,
    input  logic                   lnk_rx_valid,
    output logic                   lnk_rx_ready,
    input  logic [DATA_W-1:0]      lnk_rx_data,
    input  logic [CH_W-1:0]        lnk_rx_chan,
    output logic [N_CH-1:0]        rx_valid,
    input  logic [N_CH-1:0]        rx_ready,
    output logic [N_CH*DATA_W-1:0] rx_data,
    output logic [CNT_W-1:0]       tx_cnt,
    output logic [CNT_W-1:0]       rx_cnt,
    output logic [CNT_W-1:0]       drop_cnt
);
    typedef struct packed {
        logic [CH_W-1:0]   chan;
        logic [DATA_W-1:0] data;
    } link_word_t;

    logic [N_CH-1:0]   fifo_full;
    logic [N_CH-1:0]   fifo_empty;
    logic [N_CH-1:0]   fifo_pop;
    logic [DATA_W-1:0] fifo_dout [N_CH];
    logic [DATA_W-1:0] rx_reg    [N_CH];

    link_word_t        out_word;
    logic              out_valid;
    logic [CH_W-1:0]   last_grant;
    logic [CH_W-1:0]   grant_idx;
    logic              grant_any;
    logic              load_out;
    logic              tx_fire;
    logic              rx_fire;
    logic              rx_drop;
    logic              rx_free;
    logic [CH_W-1:0]   rx_in_chan;
    logic [DATA_W-1:0] rx_in_data;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        b2b_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .push     (tx_valid[c] && !fifo_full[c]),
            .push_data(tx_data[c*DATA_W +: DATA_W]),
            .pop      (fifo_pop[c]),
            .pop_data (fifo_dout[c]),
            .full     (fifo_full[c]),
            .empty    (fifo_empty[c])
        );
        assign fifo_pop[c] = load_out && grant_any && (grant_idx == CH_W'(c));
        assign rx_data[c*DATA_W +: DATA_W] = rx_reg[c];
    end

    assign tx_ready = ~fifo_full;

    // Round-robin: first non-empty FIFO after the last granted channel.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = 1; i <= N_CH; i++) begin
            if (!grant_any && !fifo_empty[(int'(last_grant) + i) % N_CH]) begin
                grant_any = 1'b1;
                grant_idx = CH_W'((int'(last_grant) + i) % N_CH);
            end
        end
    end

    // In loopback the held TX word feeds the RX side directly.
    assign rx_in_chan   = loopback ? out_word.chan : lnk_rx_chan;
    assign rx_in_data   = loopback ? out_word.data : lnk_rx_data;
    assign rx_drop      = ({1'b0, rx_in_chan} >= (CH_W+1)'(N_CH));
    assign rx_free      = rx_drop || !rx_valid[rx_in_chan];

    assign lnk_rx_ready = !loopback && rx_free;
    assign tx_fire      = out_valid && (loopback ? rx_free : lnk_tx_ready);
    assign rx_fire      = loopback ? tx_fire : (lnk_rx_valid && lnk_rx_ready);
    assign load_out     = !out_valid || tx_fire;

    assign lnk_tx_valid = out_valid && !loopback;
    assign lnk_tx_data  = out_word.data;
    assign lnk_tx_chan  = out_word.chan;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_word   <= '0;
            last_grant <= CH_W'(N_CH - 1);
            tx_cnt     <= CNT_W'(CNT_RESET);
            rx_cnt     <= CNT_W'(CNT_RESET);
            drop_cnt   <= CNT_W'(CNT_RESET);
        end else begin
            if (load_out) begin
                out_valid <= grant_any;
                if (grant_any) begin
                    out_word.chan <= grant_idx;
                    out_word.data <= fifo_dout[grant_idx];
                    last_grant    <= grant_idx;
                end
            end
            if (tx_fire)             tx_cnt   <= tx_cnt + 1'b1;
            if (rx_fire && !rx_drop) rx_cnt   <= rx_cnt + 1'b1;
            if (rx_fire && rx_drop)  drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // A register only loads while empty, so load and clear never coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_valid <= '0;
            for (int c = 0; c < N_CH; c++) rx_reg[c] <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (rx_fire && !rx_drop && (rx_in_chan == CH_W'(c))) begin
                    rx_valid[c] <= 1'b1;
                    rx_reg[c]   <= rx_in_data;
                end else if (rx_ready[c]) begin
                    rx_valid[c] <= 1'b0;
                end
            end
        end
    end

endmodule
